// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the fetch FSM states, the HALT opcode and the default geometry.
package busca_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCANDO,
        PARADO
    } estado_t;

    localparam logic [7:0] HALT                = 8'hFF;
    localparam int         ENDERECO_W_PADRAO   = 8;
    localparam int         PROFUNDIDADE_PADRAO = 32;

    function automatic logic e_halt(input logic [7:0] instrucao);
        return instrucao == HALT;
    endfunction

endpackage

// File: rtl/fila_instrucao.sv
// Two-entry instruction FIFO with flush; head word is 8'h00 while empty.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module fila_instrucao (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] dado_in,
    output logic [7:0] dado_out,
    output logic [1:0] contagem
);

    logic [7:0] cabeca;
    logic [7:0] cauda;
    logic       pop_ok;
    logic       push_ok;

    assign pop_ok   = pop && (contagem != 2'd0);
    assign push_ok  = push && ((contagem != 2'd2) || pop_ok);
    assign dado_out = (contagem != 2'd0) ? cabeca : 8'h00;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            contagem <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (contagem == 2'd0) cabeca <= dado_in;
                    else                  cauda  <= dado_in;
                    contagem <= contagem + 2'd1;
                end
                2'b01: begin
                    cabeca   <= cauda;
                    contagem <= contagem - 2'd1;
                end
                2'b11: begin
                    // Count stays put; the new word lands behind whatever survives the pop.
                    if (contagem == 2'd2) begin
                        cabeca <= cauda;
                        cauda  <= dado_in;
                    end else begin
                        cabeca <= dado_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: PC, jump handling and a 2-deep buffer toward decode.
// Latency: a word fetched in cycle N is presented in cycle N+1. Backpressure: fetch stalls while the buffer is full and not popped.
// Optional BUSCA_INSTRUCAO_HALT_EN: fetching 8'hFF parks the unit in PARADO until a jump or reset.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter int ENDERECO_W   = ENDERECO_W_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  habilitar,
    output logic [ENDERECO_W-1:0] ler_endereco,
    input  logic [7:0]            instrucao_in,
    input  logic                  salto_valido,
    input  logic [ENDERECO_W-1:0] salto_endereco,
    output logic [7:0]            instrucao_out,
    output logic                  instrucao_valida,
    input  logic                  pronto,
    output logic                  erro_endereco,
    output logic                  parado
);

    localparam logic [ENDERECO_W-1:0] ULTIMO = ENDERECO_W'(PROFUNDIDADE - 1);

    estado_t               estado;
    logic [ENDERECO_W-1:0] pc;
    logic [1:0]            contagem;
    logic                  pop;
    logic                  busca;
    logic                  fora;
    logic                  achou_halt;

    assign ler_endereco     = pc;
    assign instrucao_valida = contagem != 2'd0;
    assign pop              = instrucao_valida && pronto;
    assign busca            = (estado == BUSCANDO) && !salto_valido &&
                              ((contagem != 2'd2) || pop);
    assign fora             = 32'(salto_endereco) >= 32'(PROFUNDIDADE);

`ifdef BUSCA_INSTRUCAO_HALT_EN
    assign achou_halt = busca && e_halt(instrucao_in);
    assign parado     = estado == PARADO;
`else
    assign achou_halt = 1'b0;
    assign parado     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= OCIOSO;
            pc            <= '0;
            erro_endereco <= 1'b0;
        end else begin
            erro_endereco <= salto_valido && fora;
            if (salto_valido) begin
                pc <= fora ? '0 : salto_endereco;
                // A jump never wakes an idle unit; elsewhere habilitar picks the next state.
                if (estado != OCIOSO)
                    estado <= habilitar ? BUSCANDO : OCIOSO;
            end else begin
                if (busca)
                    pc <= (pc == ULTIMO) ? '0 : pc + 1'b1;
                case (estado)
                    OCIOSO:   if (habilitar) estado <= BUSCANDO;
                    BUSCANDO: begin
                        if (achou_halt)      estado <= PARADO;
                        else if (!habilitar) estado <= OCIOSO;
                    end
                    default: ;
                endcase
            end
        end
    end

    fila_instrucao u_fila (
        .clk      (clk),
        .reset    (reset),
        .push     (busca),
        .pop      (pop),
        .flush    (salto_valido),
        .dado_in  (instrucao_in),
        .dado_out (instrucao_out),
        .contagem (contagem)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Randomised and directed bench for busca_instrucao with a queue-based reference model.
// Latency: n/a. Backpressure: pronto is driven by the bench.
// Honours BUSCA_INSTRUCAO_HALT_EN in the same way as the design.
module tb_busca_instrucao;

    localparam int PROF = 32;
`ifdef BUSCA_INSTRUCAO_HALT_EN
    localparam bit HALT_ATIVO = 1'b1;
`else
    localparam bit HALT_ATIVO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       habilitar = 1'b0;
    logic       pronto = 1'b1;
    logic       salto_valido = 1'b0;
    logic [7:0] salto_endereco = 8'd0;
    logic [7:0] ler_endereco;
    logic [7:0] instrucao_in;
    logic [7:0] instrucao_out;
    logic       instrucao_valida;
    logic       erro_endereco;
    logic       parado;

    logic [7:0] mem [256];
    assign instrucao_in = mem[ler_endereco];

    always #5 clk = ~clk;

    busca_instrucao #(.ENDERECO_W(8), .PROFUNDIDADE(PROF)) dut (
        .clk              (clk),
        .reset            (reset),
        .habilitar        (habilitar),
        .ler_endereco     (ler_endereco),
        .instrucao_in     (instrucao_in),
        .salto_valido     (salto_valido),
        .salto_endereco   (salto_endereco),
        .instrucao_out    (instrucao_out),
        .instrucao_valida (instrucao_valida),
        .pronto           (pronto),
        .erro_endereco    (erro_endereco),
        .parado           (parado)
    );

    // Reference model: fila_m holds fetched-but-undelivered words in delivery order.
    byte unsigned fila_m[$];
    int  pc_m   = 0;
    int  modo_m = 0;   // 0 idle, 1 running, 2 halted
    bit  erro_m = 1'b0;
    bit  ativo  = 1'b0;

    bit  p_reset = 1'b1, p_hab = 1'b0, p_salto = 1'b0, p_pop = 1'b0;
    int  p_alvo = 0, p_cnt = 0;

    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string nome, input int obtido, input int esperado);
        n_chk++;
        if (obtido != esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, obtido, esperado, $time);
        end
    endtask

    function automatic void atualiza_modelo();
        bit busca_m;
        bit halt_m;
        busca_m = 1'b0;
        halt_m  = 1'b0;
        if (p_reset) begin
            fila_m.delete();
            pc_m   = 0;
            modo_m = 0;
            erro_m = 1'b0;
        end else if (p_salto) begin
            fila_m.delete();
            erro_m = p_alvo >= PROF;
            pc_m   = erro_m ? 0 : p_alvo;
            if (modo_m != 0) modo_m = p_hab ? 1 : 0;
        end else begin
            erro_m  = 1'b0;
            busca_m = (modo_m == 1) && (p_cnt < 2 || p_pop);
            if (busca_m) begin
                fila_m.push_back(mem[pc_m]);
                halt_m = HALT_ATIVO && (mem[pc_m] == 8'hFF);
                pc_m   = (pc_m + 1) % PROF;
            end
            if (modo_m == 0 && p_hab)       modo_m = 1;
            else if (modo_m == 1 && halt_m) modo_m = 2;
            else if (modo_m == 1 && !p_hab) modo_m = 0;
        end
    endfunction

    task automatic ciclo(input bit r, input bit h, input bit p, input bit s, input int alvo);
        @(posedge clk);
        #1;
        atualiza_modelo();
        reset          = r;
        habilitar      = h;
        pronto         = p;
        salto_valido   = s;
        salto_endereco = 8'(alvo);
        p_reset = r;
        p_hab   = h;
        p_salto = s;
        p_alvo  = alvo;
        p_cnt   = fila_m.size();
        p_pop   = p && (p_cnt > 0);
        ativo   = 1'b1;
    endtask

    // Monitor: checks every cycle, retires the head whenever decode takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (ativo) begin
                chk("ler_endereco", int'(ler_endereco), pc_m);
                chk("instrucao_valida", int'(instrucao_valida), int'(fila_m.size() > 0));
                chk("erro_endereco", int'(erro_endereco), int'(erro_m));
                chk("parado", int'(parado), int'(modo_m == 2));
                if (!instrucao_valida) begin
                    chk("instrucao_out_vazia", int'(instrucao_out), 0);
                end else if (fila_m.size() > 0) begin
                    chk("instrucao_out", int'(instrucao_out), int'(fila_m[0]));
                    if (pronto) void'(fila_m.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h01;
        mem[1] = 8'h02;
        mem[2] = 8'h03;
        mem[3] = 8'h04;
        mem[5] = 8'h55;

        repeat (3) ciclo(1, 0, 1, 0, 0);
        // Straight-line fetch with decode always ready
        repeat (8) ciclo(0, 1, 1, 0, 0);
        // Decode stalled: buffer fills with 01,02, PC parks at 2
        ciclo(1, 0, 1, 0, 0);
        repeat (5) ciclo(0, 1, 0, 0, 0);
        repeat (5) ciclo(0, 1, 1, 0, 0);
        // Jump to 5 while the buffer is full
        ciclo(1, 0, 0, 0, 0);
        repeat (4) ciclo(0, 1, 0, 0, 0);
        ciclo(0, 1, 0, 1, 5);
        repeat (5) ciclo(0, 1, 1, 0, 0);
        // Out-of-range target
        ciclo(0, 1, 1, 1, 40);
        repeat (4) ciclo(0, 1, 1, 0, 0);
        // PC wrap 31 -> 0
        ciclo(0, 1, 1, 1, 30);
        repeat (5) ciclo(0, 1, 1, 0, 0);
        // Jump while idle
        repeat (2) ciclo(0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 1, 7);
        repeat (3) ciclo(0, 0, 1, 0, 0);
        // HALT opcode at address 2, then resume by jumping to 0
        mem[2] = 8'hFF;
        ciclo(1, 0, 1, 0, 0);
        repeat (8) ciclo(0, 1, 1, 0, 0);
        ciclo(0, 1, 1, 1, 0);
        repeat (4) ciclo(0, 1, 1, 0, 0);
        mem[2] = 8'h03;
        // Reset in the middle of a stream, racing a jump
        repeat (3) ciclo(0, 1, 1, 0, 0);
        ciclo(1, 1, 1, 1, 3);
        repeat (3) ciclo(0, 1, 1, 0, 0);

        repeat (400)
            ciclo($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 63)));
        ciclo(0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
